// File: rtl/modbus_uart_rx.sv
// -----------------------------------------------------------------------------
// modbus_uart_rx
//
// Oversampling UART receiver for a Modbus RTU front end. It converts the serial
// line into byte strobes and drops bytes that fail framing or parity checks. It
// also reports the 3.5-character silence that delimits RTU frames. rxv/rxd are
// intended to drive the request parser directly.
//
// Parameters
//   PRESCALER  clock ticks per UART bit (>= 4)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2 (the second stop bit is waited out, not checked)
//   GAP_BITS   idle bit times after a stop bit that mark end of frame
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   rx          asynchronous serial input, idle high
//   rxv         one-cycle strobe: rxd holds a good byte
//   rxd         last good byte, held until the next good byte
//   frame_err   one-cycle strobe: stop bit sampled low, byte dropped
//   parity_err  one-cycle strobe: parity mismatch, byte dropped
//   gap         one-cycle strobe: GAP_BITS*PRESCALER idle ticks after a stop bit
//   busy        high while the receiver is not idle
// -----------------------------------------------------------------------------
module modbus_uart_rx #(
  parameter int PRESCALER = 100,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int GAP_BITS  = 35
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rxv,
  output logic [7:0] rxd,
  output logic       frame_err,
  output logic       parity_err,
  output logic       gap,
  output logic       busy
);

  localparam int M       = PRESCALER / 2;
  localparam int GAP_MAX = GAP_BITS * PRESCALER;
  localparam int CNT_W   = $clog2(GAP_MAX + 1);

  localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(PRESCALER - 1);
  localparam logic [CNT_W-1:0] TICK_S0    = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] TICK_S1    = CNT_W'(M);
  localparam logic [CNT_W-1:0] TICK_S2    = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] BREAK_LAST = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] GAP_FULL   = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] GAP_PRE    = CNT_W'(GAP_MAX - 1);
  localparam logic             ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STOP2,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] tick_q,    tick_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [1:0]       samp_q,    samp_d;
  logic             par_bad_q, par_bad_d;
  logic [7:0]       rxd_q,     rxd_d;
  logic             rxv_q,     rxv_d;
  logic             ferr_q,    ferr_d;
  logic             perr_q,    perr_d;
  logic             gap_q,     gap_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             busy_q;

  logic start_edge;
  logic at_sample;
  logic maj;

  // Edge detection works on the synchronized line only; the raw pin is never
  // looked at by the FSM.
  assign start_edge = rx_prev_q & ~rx_s_q;
  assign at_sample  = (tick_q == TICK_S2);

  // The third vote is the live synchronized value at tick M+1, so the decision
  // can be taken in the same cycle as the last sample.
  assign maj = (samp_q[0] & samp_q[1]) |
               (samp_q[0] & rx_s_q)    |
               (samp_q[1] & rx_s_q);

  // ---------------------------------------------------------------------------
  // Synchronizer and state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      samp_q    <= 2'b11;
      par_bad_q <= 1'b0;
      rxd_q     <= '0;
      rxv_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      gap_q     <= 1'b0;
      // Saturated so that no gap is reported before the first byte.
      gap_cnt_q <= GAP_FULL;
      busy_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      samp_q    <= samp_d;
      par_bad_q <= par_bad_d;
      rxd_q     <= rxd_d;
      rxv_q     <= rxv_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      // Derived from the next state so busy lines up with state_q exactly.
      busy_q    <= (state_d != S_IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    samp_d    = samp_q;
    par_bad_d = par_bad_q;
    rxd_d     = rxd_q;
    rxv_d     = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    gap_d     = 1'b0;
    gap_cnt_d = gap_cnt_q;

    // Free-running bit timer in every active state; it keeps running across
    // the mid-bit state changes so bit boundaries stay aligned to the start edge.
    if (state_q != S_IDLE) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + CNT_W'(1);
    end

    if (tick_q == TICK_S0) samp_d[0] = rx_s_q;
    if (tick_q == TICK_S1) samp_d[1] = rx_s_q;

    unique case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (start_edge) begin
          state_d   = S_START;
          par_bad_d = 1'b0;
        end
      end

      S_START: begin
        if (at_sample) begin
          if (!maj) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (at_sample) begin
          shift_d = {maj, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (at_sample) begin
          // XOR of data and parity bit is 1 for odd parity, 0 for even.
          par_bad_d = (((^shift_q) ^ maj) != ODD_PARITY);
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (at_sample) begin
          if (!maj) begin
            // Framing error wins over a parity error on the same byte.
            ferr_d  = 1'b1;
            state_d = S_BREAK;
            tick_d  = '0;
          end else begin
            if (par_bad_q) begin
              perr_d = 1'b1;
            end else begin
              rxv_d = 1'b1;
              rxd_d = shift_q;
            end
            if (STOP_BITS == 2) begin
              state_d = S_STOP2;
            end else begin
              state_d = S_IDLE;
            end
            tick_d = '0;
          end
        end
      end

      S_STOP2: begin
        // Second stop bit is only waited out; start edges here are ignored.
        if (tick_q == TICK_LAST) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      end

      S_BREAK: begin
        // Line must be seen high for M consecutive ticks before re-arming.
        if (rx_s_q) begin
          if (tick_q == BREAK_LAST) begin
            state_d = S_IDLE;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + CNT_W'(1);
          end
        end else begin
          tick_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase

    // Inter-frame silence counter: restarted by each stop-bit sample, counts
    // idle-high ticks, fires once on reaching the threshold, then saturates.
    if ((state_q == S_STOP) && at_sample) begin
      gap_cnt_d = '0;
    end else if (state_q == S_IDLE) begin
      if (start_edge) begin
        gap_cnt_d = '0;
      end else if (rx_s_q && (gap_cnt_q != GAP_FULL)) begin
        gap_cnt_d = gap_cnt_q + CNT_W'(1);
        gap_d     = (gap_cnt_q == GAP_PRE);
      end
    end
  end

  assign rxv        = rxv_q;
  assign rxd        = rxd_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign gap        = gap_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_modbus_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_modbus_uart_rx
//
// Directed bench for modbus_uart_rx at 16 clocks per bit. dut_a runs without
// parity, dut_b with even parity; each has its own serial line. A negedge
// monitor counts strobes and timestamps them; the stimulus block compares the
// counts, timestamps and held outputs against hand-derived values.
// -----------------------------------------------------------------------------
module tb_modbus_uart_rx;

  localparam int P       = 16;
  localparam int LAT_NP  = 2 + 1 + 9 * P + P / 2 + 2;   // 157 clocks, no parity
  localparam int LAT_P   = 2 + 1 + 10 * P + P / 2 + 2;  // 173 clocks, with parity
  localparam int GAP_T   = 35 * P;                      // 560 idle clocks
  localparam int SPIKE_J = 9;                           // clock within bit that hits the centre vote

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;

  logic       rxv_a, frame_err_a, parity_err_a, gap_a, busy_a;
  logic [7:0] rxd_a;
  logic       rxv_b, frame_err_b, parity_err_b, gap_b, busy_b;
  logic [7:0] rxd_b;

  always #5 clk = ~clk;

  modbus_uart_rx #(.PRESCALER(P), .PARITY(0), .STOP_BITS(1), .GAP_BITS(35)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_a),
    .rxv        (rxv_a),
    .rxd        (rxd_a),
    .frame_err  (frame_err_a),
    .parity_err (parity_err_a),
    .gap        (gap_a),
    .busy       (busy_a)
  );

  modbus_uart_rx #(.PRESCALER(P), .PARITY(2), .STOP_BITS(1), .GAP_BITS(35)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx_b),
    .rxv        (rxv_b),
    .rxd        (rxd_b),
    .frame_err  (frame_err_b),
    .parity_err (parity_err_b),
    .gap        (gap_b),
    .busy       (busy_b)
  );

  // ---------------------------------------------------------------------------
  // Cycle counter and strobe monitor
  // ---------------------------------------------------------------------------
  int cyc        = 0;
  int rxv_cnt_a  = 0;
  int ferr_cnt_a = 0;
  int perr_cnt_a = 0;
  int gap_cnt_a  = 0;
  int rxv_cyc_a  = 0;
  int gap_cyc_a  = 0;
  int rxv_cnt_b  = 0;
  int ferr_cnt_b = 0;
  int perr_cnt_b = 0;
  int rxv_cyc_b  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rxv_a) begin
      rxv_cnt_a <= rxv_cnt_a + 1;
      rxv_cyc_a <= cyc;
      $display("cyc %0d  A rxv        rxd=%02h", cyc, rxd_a);
    end
    if (frame_err_a) begin
      ferr_cnt_a <= ferr_cnt_a + 1;
      $display("cyc %0d  A frame_err", cyc);
    end
    if (parity_err_a) begin
      perr_cnt_a <= perr_cnt_a + 1;
      $display("cyc %0d  A parity_err", cyc);
    end
    if (gap_a) begin
      gap_cnt_a <= gap_cnt_a + 1;
      gap_cyc_a <= cyc;
      $display("cyc %0d  A gap", cyc);
    end
    if (rxv_b) begin
      rxv_cnt_b <= rxv_cnt_b + 1;
      rxv_cyc_b <= cyc;
      $display("cyc %0d  B rxv        rxd=%02h", cyc, rxd_b);
    end
    if (frame_err_b) begin
      ferr_cnt_b <= ferr_cnt_b + 1;
      $display("cyc %0d  B frame_err", cyc);
    end
    if (parity_err_b) begin
      perr_cnt_b <= perr_cnt_b + 1;
      $display("cyc %0d  B parity_err", cyc);
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line drivers
  // ---------------------------------------------------------------------------
  int start_cyc = 0;

  task automatic set_line(input bit to_b, input logic v);
    if (to_b) rx_b = v;
    else      rx_a = v;
  endtask

  // par: 0 none, 1 correct even parity, 2 inverted parity bit.
  // stop_low: 0 sends a normal stop bit, N>0 holds the line low N bit times.
  // spike_pos: frame position to receive a one-clock inversion (-1 for none).
  // max_pos: number of frame positions actually sent.
  task automatic send_frame(input bit to_b, input logic [7:0] d, input int par,
                            input int stop_low, input int spike_pos, input int max_pos);
    logic q[$];
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (par != 0) q.push_back((^d) ^ (par == 2));
    if (stop_low > 0) begin
      for (int i = 0; i < stop_low; i++) q.push_back(1'b0);
    end else begin
      q.push_back(1'b1);
    end
    for (int p = 0; p < q.size() && p < max_pos; p++) begin
      for (int j = 0; j < P; j++) begin
        @(negedge clk);
        if (p == 0 && j == 0) start_cyc = cyc;
        set_line(to_b, (p == spike_pos && j == SPIKE_J) ? ~q[p] : q[p]);
      end
    end
  endtask

  task automatic idle(input bit to_b, input int n);
    @(negedge clk);
    set_line(to_b, 1'b1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int base;
    int fbase;
    int pbase;
    int gbase;
    int s0;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(0, 4);

    // Reset state
    check("reset_rxd_a", rxd_a, 8'h00);
    check("reset_rxd_b", rxd_b, 8'h00);
    check("reset_busy_a", busy_a, 1'b0);
    check("reset_strobes_a", {rxv_a, frame_err_a, parity_err_a, gap_a}, 4'b0000);
    idle(0, 2 * P);

    // 1. Two bytes back to back, exact strobe latency
    base = rxv_cnt_a;
    send_frame(0, 8'h02, 0, 0, -1, 99);
    s0 = start_cyc;
    check("t1_cnt0", rxv_cnt_a - base, 1);
    check("t1_rxd0", rxd_a, 8'h02);
    check("t1_lat0", rxv_cyc_a - s0, LAT_NP);
    send_frame(0, 8'h03, 0, 0, -1, 99);
    s0 = start_cyc;
    check("t1_cnt1", rxv_cnt_a - base, 2);
    check("t1_rxd1", rxd_a, 8'h03);
    check("t1_lat1", rxv_cyc_a - s0, LAT_NP);
    idle(0, 40 * P);

    // 2. Even parity on dut_b
    base  = rxv_cnt_b;
    pbase = perr_cnt_b;
    send_frame(1, 8'hA5, 1, 0, -1, 99);
    s0 = start_cyc;
    idle(1, 4 * P);
    check("t2_good_cnt", rxv_cnt_b - base, 1);
    check("t2_good_rxd", rxd_b, 8'hA5);
    check("t2_good_lat", rxv_cyc_b - s0, LAT_P);
    send_frame(1, 8'hA5, 2, 0, -1, 99);
    idle(1, 4 * P);
    check("t2_bad_perr", perr_cnt_b - pbase, 1);
    check("t2_bad_rxv", rxv_cnt_b - base, 1);
    check("t2_bad_rxd", rxd_b, 8'hA5);
    send_frame(1, 8'h01, 2, 0, -1, 99);
    idle(1, 4 * P);
    check("t2_bad2_perr", perr_cnt_b - pbase, 2);
    check("t2_bad2_rxd", rxd_b, 8'hA5);
    send_frame(1, 8'h01, 1, 0, -1, 99);
    idle(1, 4 * P);
    check("t2_good2_rxd", rxd_b, 8'h01);
    check("t2_good2_cnt", rxv_cnt_b - base, 2);
    check("t2_ferr_none", ferr_cnt_b, 0);

    // 3. Stop bit held low for three bit times
    base  = rxv_cnt_a;
    fbase = ferr_cnt_a;
    pbase = perr_cnt_a;
    send_frame(0, 8'h55, 0, 3, -1, 99);
    check("t3_busy_break", busy_a, 1'b1);
    idle(0, 40 * P);
    check("t3_ferr", ferr_cnt_a - fbase, 1);
    check("t3_no_rxv", rxv_cnt_a - base, 0);
    check("t3_no_perr", perr_cnt_a - pbase, 0);
    check("t3_rxd_held", rxd_a, 8'h03);
    check("t3_idle", busy_a, 1'b0);
    send_frame(0, 8'h11, 0, 0, -1, 99);
    idle(0, 4 * P);
    check("t3_next_cnt", rxv_cnt_a - base, 1);
    check("t3_next_rxd", rxd_a, 8'h11);

    // 4a. Four-clock glitch: START is entered, then abandoned silently
    base  = rxv_cnt_a;
    fbase = ferr_cnt_a;
    @(negedge clk);
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    rx_a = 1'b1;
    check("t4_glitch_busy", busy_a, 1'b1);
    repeat (3 * P) @(negedge clk);
    #1;
    check("t4_glitch_idle", busy_a, 1'b0);
    check("t4_glitch_rxv", rxv_cnt_a - base, 0);
    check("t4_glitch_ferr", ferr_cnt_a - fbase, 0);

    // 4b. One-clock spike on the centre sample of data bit 2 of 0x3C
    send_frame(0, 8'h3C, 0, 0, 3, 99);
    idle(0, 40 * P);
    check("t4_spike_cnt", rxv_cnt_a - base, 1);
    check("t4_spike_rxd", rxd_a, 8'h3C);

    // 5. End-of-frame silence
    gbase = gap_cnt_a;
    send_frame(0, 8'h02, 0, 0, -1, 99);
    s0 = rxv_cyc_a;
    idle(0, 700);
    check("t5_gap_once", gap_cnt_a - gbase, 1);
    check("t5_gap_time", gap_cyc_a - s0, GAP_T);
    idle(0, 1200);
    check("t5_gap_no_repeat", gap_cnt_a - gbase, 1);
    base = rxv_cnt_a;
    send_frame(0, 8'h04, 0, 0, -1, 99);
    idle(0, 20 * P);
    send_frame(0, 8'h08, 0, 0, -1, 99);
    check("t5_two_bytes", rxv_cnt_a - base, 2);
    check("t5_no_gap_between", gap_cnt_a - gbase, 1);
    idle(0, 700);
    check("t5_gap_after_second", gap_cnt_a - gbase, 2);

    // 6. Reset during data bit 4 of 0x7E
    base  = rxv_cnt_a;
    gbase = gap_cnt_a;
    send_frame(0, 8'h7E, 0, 0, -1, 5);
    @(negedge clk);
    rx_a = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_busy_pre_rst", busy_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rxd_rst", rxd_a, 8'h00);
    check("t6_busy_rst", busy_a, 1'b0);
    check("t6_strobes_rst", {rxv_a, frame_err_a, parity_err_a, gap_a}, 4'b0000);
    idle(0, 700);
    check("t6_no_rxv", rxv_cnt_a - base, 0);
    check("t6_no_gap_after_rst", gap_cnt_a - gbase, 0);
    send_frame(0, 8'h81, 0, 0, -1, 99);
    idle(0, 4 * P);
    check("t6_next_cnt", rxv_cnt_a - base, 1);
    check("t6_next_rxd", rxd_a, 8'h81);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
